// File: rtl/scatter_sequencer.sv
// scatter_sequencer: walks one vertex's adjacency list in edge memory and
// emits one scatter message per neighbor, holding each message until the
// downstream scatter path acknowledges it. Barrier updates become a single
// barrier message so per-round ordering is kept.
module scatter_sequencer #(
   parameter int NODEID_WIDTH = 32,
   parameter int ADDR_WIDTH   = 16,
   parameter int COUNT_WIDTH  = 32
) (
   input  logic                    sys_clk,
   input  logic                    sys_rst_n,
   input  logic [NODEID_WIDTH-1:0] update_sender,
   input  logic [ADDR_WIDTH-1:0]   update_start_addr,
   input  logic [COUNT_WIDTH-1:0]  update_num_neighbors,
   input  logic [1:0]              update_round,
   input  logic                    update_barrier,
   input  logic                    update_valid,
   output logic                    update_ready,
   output logic                    mem_rd_en,
   output logic [ADDR_WIDTH-1:0]   mem_addr,
   input  logic [NODEID_WIDTH-1:0] mem_rd_data,
   output logic [NODEID_WIDTH-1:0] neighbor_out,
   output logic [NODEID_WIDTH-1:0] sender_out,
   output logic [1:0]              round_out,
   output logic                    barrier_out,
   output logic                    valid_out,
   input  logic                    message_ack,
   output logic                    busy,
   output logic [31:0]             msg_count
);

   typedef enum logic [2:0] {
      IDLE,
      READ,
      LOAD,
      OUT,
      BAR
   } state_t;

   state_t                  state;
   state_t                  state_next;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [COUNT_WIDTH-1:0]  remaining_q;
   logic [NODEID_WIDTH-1:0] sender_q;
   logic [NODEID_WIDTH-1:0] neighbor_q;
   logic [1:0]              round_q;
   logic [31:0]             count_q;
   logic                    last_neighbor;

   assign last_neighbor = (remaining_q == COUNT_WIDTH'(1));

   // State register; reset aborts any walk in progress.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state decode and per-state control strobes.
   always_comb begin
      state_next   = state;
      update_ready = 1'b0;
      mem_rd_en    = 1'b0;
      valid_out    = 1'b0;
      barrier_out  = 1'b0;
      case (state)
         IDLE: begin
            // gated by reset so upstream never sees ready while held in reset
            update_ready = sys_rst_n;
            if (update_valid) begin
               if (update_barrier) begin
                  state_next = BAR;
               end else if (update_num_neighbors != '0) begin
                  state_next = READ;
               end
            end
         end
         READ: begin
            mem_rd_en  = 1'b1;
            state_next = LOAD;
         end
         LOAD: begin
            state_next = OUT;
         end
         OUT: begin
            valid_out = 1'b1;
            if (message_ack) begin
               state_next = last_neighbor ? IDLE : READ;
            end
         end
         BAR: begin
            valid_out   = 1'b1;
            barrier_out = 1'b1;
            if (message_ack) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Update latching, adjacency walk pointers, neighbor capture and message count.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         addr_q      <= '0;
         remaining_q <= '0;
         sender_q    <= '0;
         neighbor_q  <= '0;
         round_q     <= '0;
         count_q     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (update_valid) begin
                  if (update_barrier) begin
                     sender_q <= update_sender;
                     round_q  <= update_round;
                  end else if (update_num_neighbors != '0) begin
                     sender_q    <= update_sender;
                     round_q     <= update_round;
                     addr_q      <= update_start_addr;
                     remaining_q <= update_num_neighbors;
                  end
               end
            end
            LOAD: begin
               neighbor_q <= mem_rd_data;
            end
            OUT: begin
               if (message_ack) begin
                  count_q <= count_q + 32'd1;
                  if (!last_neighbor) begin
                     remaining_q <= remaining_q - COUNT_WIDTH'(1);
                     addr_q      <= addr_q + ADDR_WIDTH'(1);
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign neighbor_out = (state == BAR) ? '0 : neighbor_q;
   assign sender_out   = sender_q;
   assign round_out    = round_q;
   assign mem_addr     = addr_q;
   assign busy         = (state != IDLE);
   assign msg_count    = count_q;

endmodule

// File: tb/tb_scatter_sequencer.sv
// Self-checking bench for scatter_sequencer: random and directed updates are
// checked against a reference that derives each expected message list straight
// from the edge-memory contents and the update fields.
module tb_scatter_sequencer;

   logic        sys_clk;
   logic        sys_rst_n;
   logic [31:0] update_sender;
   logic [15:0] update_start_addr;
   logic [31:0] update_num_neighbors;
   logic [1:0]  update_round;
   logic        update_barrier;
   logic        update_valid;
   logic        update_ready;
   logic        mem_rd_en;
   logic [15:0] mem_addr;
   logic [31:0] mem_rd_data;
   logic [31:0] neighbor_out;
   logic [31:0] sender_out;
   logic [1:0]  round_out;
   logic        barrier_out;
   logic        valid_out;
   logic        message_ack;
   logic        busy;
   logic [31:0] msg_count;

   logic [31:0] mem [0:65535];
   logic [31:0] exp_count;
   int          checks = 0;
   int          passed = 0;

   scatter_sequencer #(
      .NODEID_WIDTH(32),
      .ADDR_WIDTH  (16),
      .COUNT_WIDTH (32)
   ) dut (
      .sys_clk             (sys_clk),
      .sys_rst_n           (sys_rst_n),
      .update_sender       (update_sender),
      .update_start_addr   (update_start_addr),
      .update_num_neighbors(update_num_neighbors),
      .update_round        (update_round),
      .update_barrier      (update_barrier),
      .update_valid        (update_valid),
      .update_ready        (update_ready),
      .mem_rd_en           (mem_rd_en),
      .mem_addr            (mem_addr),
      .mem_rd_data         (mem_rd_data),
      .neighbor_out        (neighbor_out),
      .sender_out          (sender_out),
      .round_out           (round_out),
      .barrier_out         (barrier_out),
      .valid_out           (valid_out),
      .message_ack         (message_ack),
      .busy                (busy),
      .msg_count           (msg_count)
   );

   initial begin
      sys_clk = 1'b0;
      forever #5 sys_clk = ~sys_clk;
   end

   // Edge memory: data one cycle after the strobe, junk otherwise.
   always @(posedge sys_clk) begin
      if (mem_rd_en) mem_rd_data <= mem[mem_addr];
      else           mem_rd_data <= $urandom;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   task automatic junk_update_fields;
      update_sender        = $urandom;
      update_start_addr    = 16'($urandom);
      update_num_neighbors = $urandom;
      update_round         = 2'($urandom);
      update_barrier       = 1'($urandom);
   endtask

   // Walk of n neighbors from st; optional stall of stall_len cycles on message stall_idx.
   task automatic do_walk(input logic [31:0] snd, input logic [15:0] st, input int n,
                          input logic [1:0] rnd, input int stall_idx, input int stall_len);
      logic [31:0] exp_nb[$];
      logic [15:0] a;
      int idx, c, rd_cnt, stall_done, last_ack;
      bit seen;
      for (int i = 0; i < n; i++) begin
         a = st + 16'(i);
         exp_nb.push_back(mem[a]);
      end
      idx = 0; c = 0; rd_cnt = 0; stall_done = 0; last_ack = 0; seen = 0;
      update_valid = 1'b1; update_sender = snd; update_start_addr = st;
      update_num_neighbors = 32'(n); update_round = rnd; update_barrier = 1'b0;
      checks++;
      if (update_ready !== 1'b1) $display("FAIL walk_ready_start: update_ready=%b required 1", update_ready);
      else passed++;
      @(posedge sys_clk);
      while (idx < n && c < 20 * n + 20) begin
         @(negedge sys_clk);
         c++;
         update_valid = 1'($urandom);
         junk_update_fields();
         message_ack = 1'b1;
         if (mem_rd_en) begin
            a = st + 16'(rd_cnt);
            checks++;
            if (mem_addr !== a || c != ((rd_cnt == 0) ? 1 : last_ack + 1))
               $display("FAIL walk_read: addr=%h cycle=%0d required addr=%h cycle=%0d",
                        mem_addr, c, a, (rd_cnt == 0) ? 1 : last_ack + 1);
            else passed++;
            rd_cnt++;
         end
         if (valid_out) begin
            if (!seen) begin
               checks++;
               if (c != ((idx == 0) ? 3 : last_ack + 3))
                  $display("FAIL walk_latency: msg %0d at cycle %0d required %0d",
                           idx, c, (idx == 0) ? 3 : last_ack + 3);
               else passed++;
               seen = 1;
            end
            checks++;
            if ({barrier_out, neighbor_out, sender_out, round_out} !== {1'b0, exp_nb[idx], snd, rnd})
               $display("FAIL walk_msg: msg %0d got b=%b nb=%h s=%h r=%0d required b=0 nb=%h s=%h r=%0d",
                        idx, barrier_out, neighbor_out, sender_out, round_out, exp_nb[idx], snd, rnd);
            else passed++;
            if (idx == stall_idx && stall_done < stall_len) begin
               message_ack = 1'b0;
               stall_done++;
            end else begin
               idx++;
               exp_count = exp_count + 32'd1;
               last_ack = c;
               seen = 0;
            end
         end
      end
      if (idx < n) begin
         checks++;
         $display("FAIL walk_timeout: %0d of %0d messages seen, required all", idx, n);
      end else begin
         @(negedge sys_clk);
         update_valid = 1'b0;
         message_ack  = 1'b0;
         checks++;
         if ({update_ready, busy, valid_out, mem_rd_en} !== 4'b1000)
            $display("FAIL walk_end_idle: ready/busy/valid/rd=%b required 1000",
                     {update_ready, busy, valid_out, mem_rd_en});
         else passed++;
         checks++;
         if (msg_count !== exp_count || rd_cnt != n)
            $display("FAIL walk_count: msg_count=%0d reads=%0d required %0d and %0d",
                     msg_count, rd_cnt, exp_count, n);
         else passed++;
      end
   endtask

   task automatic do_barrier(input logic [31:0] snd, input logic [1:0] rnd, input int hold);
      int c, stalled;
      bit done, rd_seen;
      c = 0; stalled = 0; done = 0; rd_seen = 0;
      update_valid = 1'b1; update_sender = snd; update_round = rnd; update_barrier = 1'b1;
      update_start_addr = 16'($urandom); update_num_neighbors = $urandom;
      checks++;
      if (update_ready !== 1'b1) $display("FAIL bar_ready_start: update_ready=%b required 1", update_ready);
      else passed++;
      @(posedge sys_clk);
      while (!done && c < 20) begin
         @(negedge sys_clk);
         c++;
         update_valid = 1'($urandom);
         junk_update_fields();
         if (mem_rd_en) rd_seen = 1;
         checks++;
         if ({valid_out, barrier_out, neighbor_out, sender_out, round_out, update_ready}
             !== {1'b1, 1'b1, 32'd0, snd, rnd, 1'b0})
            $display("FAIL bar_msg: cycle %0d v=%b b=%b nb=%h s=%h r=%0d rdy=%b required v=1 b=1 nb=0 s=%h r=%0d rdy=0",
                     c, valid_out, barrier_out, neighbor_out, sender_out, round_out, update_ready, snd, rnd);
         else passed++;
         if (stalled < hold) begin
            message_ack = 1'b0;
            stalled++;
         end else begin
            message_ack = 1'b1;
            done = 1;
         end
      end
      @(negedge sys_clk);
      update_valid = 1'b0;
      message_ack  = 1'b0;
      checks++;
      if ({update_ready, busy, valid_out} !== 3'b100 || msg_count !== exp_count || rd_seen)
         $display("FAIL bar_end: ready/busy/valid=%b count=%0d read=%b required 100 count=%0d read=0",
                  {update_ready, busy, valid_out}, msg_count, rd_seen, exp_count);
      else passed++;
   endtask

   task automatic do_zero(input logic [31:0] snd);
      update_valid = 1'b1; update_sender = snd; update_start_addr = 16'($urandom);
      update_num_neighbors = 32'd0; update_round = 2'($urandom); update_barrier = 1'b0;
      message_ack = 1'b1;
      checks++;
      if (update_ready !== 1'b1) $display("FAIL zero_ready_start: update_ready=%b required 1", update_ready);
      else passed++;
      @(posedge sys_clk);
      @(negedge sys_clk);
      update_valid = 1'b0;
      message_ack  = 1'b0;
      checks++;
      if ({update_ready, busy, valid_out, mem_rd_en} !== 4'b1000 || msg_count !== exp_count)
         $display("FAIL zero_consume: ready/busy/valid/rd=%b count=%0d required 1000 count=%0d",
                  {update_ready, busy, valid_out, mem_rd_en}, msg_count, exp_count);
      else passed++;
   endtask

   task automatic test_reset;
      sys_rst_n = 1'b1;
      update_valid = 1'b0;
      message_ack  = 1'b0;
      junk_update_fields();
      #1 sys_rst_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge sys_clk);
         update_valid = 1'($urandom);
         message_ack  = 1'($urandom);
         junk_update_fields();
      end
      #1;
      checks++;
      if ({valid_out, barrier_out, mem_rd_en, busy, update_ready} !== 5'b0)
         $display("FAIL reset_flags: v/b/rd/busy/rdy=%b required 00000",
                  {valid_out, barrier_out, mem_rd_en, busy, update_ready});
      else passed++;
      checks++;
      if (neighbor_out !== 32'd0 || sender_out !== 32'd0 || round_out !== 2'd0 ||
          mem_addr !== 16'd0 || msg_count !== 32'd0)
         $display("FAIL reset_values: nb=%h s=%h r=%0d addr=%h cnt=%0d required all 0",
                  neighbor_out, sender_out, round_out, mem_addr, msg_count);
      else passed++;
      @(negedge sys_clk);
      update_valid = 1'b0;
      message_ack  = 1'b0;
      sys_rst_n    = 1'b1;
      #1;
      checks++;
      if ({update_ready, busy} !== 2'b10)
         $display("FAIL reset_release: ready/busy=%b required 10", {update_ready, busy});
      else passed++;
      exp_count = 32'd0;
      @(negedge sys_clk);
   endtask

   task automatic test_basic;
      mem[16'h0010] = 32'd5;
      mem[16'h0011] = 32'd9;
      mem[16'h0012] = 32'd7;
      do_walk(32'd3, 16'h0010, 3, 2'd1, -1, 0);
   endtask

   task automatic test_backpressure;
      do_walk(32'd3, 16'h0010, 3, 2'd1, 1, 4);
   endtask

   task automatic test_zero_and_barrier;
      do_zero(32'd44);
      do_barrier(32'd8, 2'd2, 0);
      do_barrier(32'h1234_5678, 2'd3, 3);
   endtask

   task automatic test_addr_wrap;
      do_walk($urandom, 16'hFFFF, 2, 2'($urandom), -1, 0);
   endtask

   task automatic test_back_to_back;
      for (int i = 0; i < 14; i++) begin
         int unsigned kind;
         kind = $urandom_range(0, 9);
         if (kind < 2)      do_barrier($urandom, 2'($urandom), $urandom_range(0, 2));
         else if (kind < 3) do_zero($urandom);
         else do_walk($urandom,
                      ($urandom_range(0, 1) == 1) ? 16'($urandom_range(16'hFFFA, 16'hFFFF)) : 16'($urandom),
                      $urandom_range(1, 5), 2'($urandom), $urandom_range(0, 4), $urandom_range(0, 3));
      end
   endtask

   task automatic test_reset_mid;
      int acks, c;
      bit hit;
      acks = 0; c = 0; hit = 0;
      update_valid = 1'b1; update_sender = 32'd77; update_start_addr = 16'h0100;
      update_num_neighbors = 32'd4; update_round = 2'd0; update_barrier = 1'b0;
      message_ack = 1'b1;
      @(posedge sys_clk);
      while (!hit && c < 40) begin
         @(negedge sys_clk);
         c++;
         update_valid = 1'b0;
         if (valid_out) begin
            if (acks == 1) hit = 1;
            else acks++;
         end
      end
      if (!hit) begin
         checks++;
         $display("FAIL midreset_timeout: second message not seen, required by cycle 40");
      end else begin
         message_ack = 1'b0;
         #2 sys_rst_n = 1'b0;
         #1;
         checks++;
         if ({valid_out, busy, update_ready, mem_rd_en} !== 4'b0 || msg_count !== 32'd0)
            $display("FAIL midreset_abort: v/busy/rdy/rd=%b count=%0d required 0000 count=0",
                     {valid_out, busy, update_ready, mem_rd_en}, msg_count);
         else passed++;
         exp_count = 32'd0;
         @(negedge sys_clk);
         sys_rst_n = 1'b1;
         #1;
         checks++;
         if ({update_ready, busy} !== 2'b10)
            $display("FAIL midreset_release: ready/busy=%b required 10", {update_ready, busy});
         else passed++;
         @(negedge sys_clk);
         do_walk(32'd78, 16'h0200, 3, 2'd1, -1, 0);
      end
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = $urandom;
      exp_count = 32'd0;
      test_reset();
      test_basic();
      test_backpressure();
      test_zero_and_barrier();
      test_addr_wrap();
      test_back_to_back();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
